// File: rtl/io_bridge_pkg.sv
// Shared types and helpers for the lisp_core I/O bridge family.
package io_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wider than any peripheral bus; users slice the low IO_DATA_BITS.
    localparam logic [63:0] IO_TIMEOUT_FILL = '1;

    function automatic logic [63:0] window_mask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= lo && i <= hi) m[i[5:0]] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/io_channel_mux.sv
// Picks the ack bit and read-data slice of one peripheral channel; purely combinational.
// No state and no flow control of its own: the caller owns the handshake.
module io_channel_mux
    import io_bridge_pkg::*;
#(
    parameter int CH_BITS      = 2,
    parameter int IO_DATA_BITS = 16
) (
    input  logic [CH_BITS-1:0]                   channel,
    input  logic [(2**CH_BITS)-1:0]              ack,
    input  logic [(2**CH_BITS)*IO_DATA_BITS-1:0] read_value,
    output logic                                 sel_ack,
    output logic [IO_DATA_BITS-1:0]              sel_data
);

    assign sel_ack  = ack[channel];
    assign sel_data = read_value[int'(channel)*IO_DATA_BITS +: IO_DATA_BITS];

endmodule

// File: rtl/io_bridge.sv
// Memory/peripheral bridge for lisp_core: memory accesses pass with no added latency, I/O takes >= 3 cycles.
// Core is stalled until ack, or until forced completion when IO_BRIDGE_TIMEOUT_EN is defined.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int WORD_SIZE      = 20,
    parameter int IO_ADDR_BITS   = 16,
    parameter int INDEX_BITS     = 7,
    parameter int CH_BITS        = 2,
    parameter int IO_DATA_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [WORD_SIZE-1:0]                 core_addr,
    input  logic [WORD_SIZE-1:0]                 core_write_value,
    input  logic                                 core_write_enable,
    output logic [WORD_SIZE-1:0]                 core_read_value,
    output logic                                 core_stall,
    output logic                                 mem_write_enable,
    input  logic [WORD_SIZE-1:0]                 mem_read_value,
    output logic                                 io_request,
    output logic                                 io_write,
    output logic [CH_BITS-1:0]                   io_channel,
    output logic [INDEX_BITS-1:0]                io_index,
    output logic [IO_DATA_BITS-1:0]              io_write_value,
    input  logic [(2**CH_BITS)-1:0]              io_ack,
    input  logic [(2**CH_BITS)*IO_DATA_BITS-1:0] io_read_value,
    output logic                                 io_timeout
);

    localparam int          WIN_LO   = INDEX_BITS + CH_BITS;
    localparam logic [63:0] WIN_MASK = window_mask(WIN_LO, IO_ADDR_BITS - 1);

    state_t                 state;
    logic                   io_hit;
    logic                   last_was_io;
    logic [WORD_SIZE-1:0]   io_data_q;
    logic                   sel_ack;
    logic [IO_DATA_BITS-1:0] sel_data;

    assign io_hit = ((64'(core_addr) & WIN_MASK) == WIN_MASK);

    assign mem_write_enable = core_write_enable && !io_hit;
    // Gated by reset so an I/O address held during reset does not freeze the core.
    assign core_stall       = reset_n && ((state == IDLE && io_hit) || state == WAIT);
    assign core_read_value  = last_was_io ? io_data_q : mem_read_value;

    io_channel_mux #(
        .CH_BITS      (CH_BITS),
        .IO_DATA_BITS (IO_DATA_BITS)
    ) u_mux (
        .channel    (io_channel),
        .ack        (io_ack),
        .read_value (io_read_value),
        .sel_ack    (sel_ack),
        .sel_data   (sel_data)
    );

    if (WORD_SIZE > IO_DATA_BITS) begin : g_wdata_unused
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^core_write_value[WORD_SIZE-1:IO_DATA_BITS];
    end

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    assign io_timeout = timeout_q;
`else
    assign io_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            io_request     <= 1'b0;
            io_write       <= 1'b0;
            io_channel     <= '0;
            io_index       <= '0;
            io_write_value <= '0;
            io_data_q      <= '0;
            last_was_io    <= 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            wait_cnt       <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            // Only DONE retires an I/O access without stalling, so this marks the read source.
            if (!core_stall) last_was_io <= (state == DONE);
            case (state)
                IDLE: begin
                    if (io_hit) begin
                        state          <= WAIT;
                        io_request     <= 1'b1;
                        io_write       <= core_write_enable;
                        io_channel     <= core_addr[WIN_LO-1:INDEX_BITS];
                        io_index       <= core_addr[INDEX_BITS-1:0];
                        io_write_value <= core_write_value[IO_DATA_BITS-1:0];
`ifdef IO_BRIDGE_TIMEOUT_EN
                        wait_cnt       <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (sel_ack) begin
                        if (!io_write) io_data_q <= WORD_SIZE'(sel_data);
                        state      <= DONE;
                        io_request <= 1'b0;
                    end
`ifdef IO_BRIDGE_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        io_data_q  <= WORD_SIZE'(IO_TIMEOUT_FILL[IO_DATA_BITS-1:0]);
                        timeout_q  <= 1'b1;
                        state      <= DONE;
                        io_request <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Parametrised memory-mapped I/O bridge between lisp_core and both data memory and a set of peripheral register channels.
- Decodes a high address window, splits it into NUM_CHANNELS channels of 2^INDEX_BITS registers, and runs a request/acknowledge transaction per access.
- Stalls the core until the peripheral acknowledges or a timeout expires.
- Steers the one-cycle-late read data between memory and the I/O path.

Parameters:
WORD_SIZE, 20, core data and address width
IO_ADDR_BITS, 16, low address bits examined by the window decode
INDEX_BITS, 7, register index width within a channel
CH_BITS, 2, channel select width; NUM_CHANNELS = 2**CH_BITS
IO_DATA_BITS, 16, peripheral data width (must be <= WORD_SIZE)
TIMEOUT_CYCLES, 15, wait cycles before forced completion (must be >= 1)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
core_addr  in  WORD_SIZE  core memory address
core_write_value  in  WORD_SIZE  core write data
core_write_enable  in  1  core write strobe
core_read_value  out  WORD_SIZE  read data returned to core
core_stall  out  1  core must hold addr/data/enable while high
mem_write_enable  out  1  qualified write strobe to data memory
mem_read_value  in  WORD_SIZE  data memory output (1-cycle latency)
io_request  out  1  peripheral transaction pending
io_write  out  1  1 = write, 0 = read; valid while io_request
io_channel  out  CH_BITS  target channel
io_index  out  INDEX_BITS  register index
io_write_value  out  IO_DATA_BITS  write data, low bits of core_write_value
io_ack  in  NUM_CHANNELS  per-channel acknowledge
io_read_value  in  NUM_CHANNELS*IO_DATA_BITS  per-channel read data, channel c at [c*IO_DATA_BITS +: IO_DATA_BITS]
io_timeout  out  1  sticky: a transaction timed out

Behaviour:
- io_hit: core_addr[IO_ADDR_BITS-1 : INDEX_BITS+CH_BITS] all ones.
  - channel = core_addr[INDEX_BITS+CH_BITS-1 : INDEX_BITS]
  - index = core_addr[INDEX_BITS-1:0]
  - Defaults: window is bits 15:9 all ones, channel is 8:7, index is 6:0.
- mem_write_enable = core_write_enable && !io_hit (combinational). Memory is never written for I/O addresses.
- States:
  - IDLE: if io_hit, latch channel, index, write flag and write data; go to WAIT; clear the wait counter.
  - WAIT:
    - io_ack[io_channel] high: latch io_read_value slice (zero-extended to WORD_SIZE, reads only) into io_data_q; go to DONE.
    - Else counter == TIMEOUT_CYCLES-1: io_data_q = all ones in low IO_DATA_BITS, upper bits zero; set io_timeout; go to DONE.
    - Else increment the counter.
  - DONE: go to IDLE unconditionally. No new issue in this cycle even though io_hit is still true.
- io_request is registered: high exactly while in WAIT. io_write, io_channel and io_index are driven from latched registers.
- Acks on non-selected channels are ignored. Acks outside WAIT are ignored.
- core_stall = (IDLE && io_hit) || WAIT (combinational). It is low in DONE, so the access retires at the end of DONE.
- Read steering:
  - last_was_io is registered each un-stalled cycle: 1 when retiring from DONE, 0 for memory accesses.
  - core_read_value = last_was_io ? io_data_q : mem_read_value.
  - Memory accesses: zero added latency, no stall.
- Minimum I/O access: 3 cycles (issue, WAIT with ack, DONE). Back-to-back I/O accesses pass through IDLE between transactions.
- Reset (async, any state):
  - State goes to IDLE.
  - io_request, io_write, io_timeout and last_was_io go to 0.
  - io_channel, io_index, io_write_value and io_data_q go to 0.
  - The wait counter clears.
  - core_stall is 0 while reset_n is low.
  - A transaction interrupted by reset is abandoned; no completion is reported.
- io_timeout is cleared only by reset.

Optional Feature:
- Macro: IO_BRIDGE_TIMEOUT_EN.
- Defined: timeout counter, forced completion and io_timeout behave as above.
- Undefined:
  - No counter is built.
  - WAIT holds indefinitely until the selected ack arrives.
  - io_timeout is tied to 0.
  - TIMEOUT_CYCLES is ignored.

Decomposition:
- Package io_bridge_pkg:
  - state enum (IDLE, WAIT, DONE)
  - IO_TIMEOUT_FILL constant (all-ones read fill)
  - helper function for the window-match mask
- One sub-module, io_channel_mux: combinational selection of the io_ack bit and io_read_value slice by latched channel. Reused by later multi-master bridges.

Test Plan:
- Memory path: write 0x12345 to addr 0x00100, then read it back → mem_write_enable 1 for that cycle, core_stall never high, core_read_value 0x12345 one cycle after the read.
- I/O read, channel 2 index 5 (addr 0x0FF05), ack after 2 WAIT cycles with data 0xBEEF:
  - io_channel=2, io_index=5, io_write=0.
  - Stall for 4 cycles.
  - core_read_value 0x0BEEF the cycle after DONE.
  - io_timeout 0.
- I/O write 0x0A5A5 to channel 0 index 0 (0x0FE00), immediate ack:
  - io_write=1, io_write_value 0xA5A5.
  - mem_write_enable stays 0.
  - Total stall 2 cycles.
- Wrong-channel ack: request to channel 1; pulse io_ack[3] and then io_ack[0] → still in WAIT; completes only on io_ack[1].
- Timeout (macro defined), no ack → DONE after 15 WAIT cycles, core_read_value 0x0FFFF, io_timeout stays 1 through further good transactions.
- reset_n low mid-WAIT:
  - io_request and core_stall drop immediately.
  - After release, a new read to 0x0FF80 issues cleanly with io_channel=3, io_index=0.
